moldudp64_msg_tracker: RTL

- Sequential successor to the combinational overlap detector.
- Sniffs the MoldUDP64 payload AXI-stream after the 20-byte header has been stripped. Tracks bytes left in the current message across beats and captures each 2-byte big-endian length field, including fields split across beats.
- Flags per beat where a message ends, where the next one starts, and whether they overlap in the same beat.
- Sits beside the message demux and feeds it boundary offsets. It has no backpressure of its own.

---
 rtl/moldudp64_msg_tracker.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/moldudp64_msg_tracker.sv
// MoldUDP64 payload message-boundary tracker: per-beat end/start/length flags.
// Optional message counter enabled with `define MOLD_MSG_CNT_EN.
module moldudp64_msg_tracker #(
  parameter int P_L = 8,
  parameter int ML_W = 16,
  localparam int P_L_LOG2 = $clog2(P_L)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [P_L*8-1:0]    data_i,
  input  logic [P_L-1:0]      keep_i,
  input  logic                last_i,
  output logic                valid_o,
  output logic                msg_end_o,
  output logic [P_L_LOG2-1:0] msg_end_off_o,
  output logic                msg_start_o,
  output logic [P_L_LOG2-1:0] msg_start_off_o,
  output logic                overlap_o,
  output logic                len_v_o,
  output logic [ML_W-1:0]     len_o,
  output logic                err_o
`ifdef MOLD_MSG_CNT_EN
  ,
  input  logic [15:0]         hdr_cnt_i,
  output logic [15:0]         msg_cnt_o,
  output logic                cnt_mismatch_o
`endif
);

  typedef enum logic [1:0] {S_LEN, S_SPLIT, S_BODY, S_DRAIN} state_t;

  localparam logic [ML_W-1:0] PL_W  = ML_W'(P_L);
  localparam logic [ML_W-1:0] PL_M1 = ML_W'(P_L - 1);
  localparam logic [ML_W-1:0] PL_M2 = ML_W'(P_L - 2);

  state_t state_q, state_d;
  logic [ML_W-1:0] rem_q, rem_d;
  logic [7:0] held_q, held_d;

  logic valid_q, valid_d, end_q, end_d, start_q, start_d;
  logic ovl_q, ovl_d, lv_q, lv_d, err_q, err_d;
  logic [P_L_LOG2-1:0] eoff_q, eoff_d, soff_q, soff_d;
  logic [ML_W-1:0] len_q, len_d;

  logic e_c, s_c, lv_c, chk_c, err_c;
  logic [P_L_LOG2-1:0] eo_c, so_c, r_c;
  logic [ML_W-1:0] len_c, bod_c, n_c;

  function automatic logic [7:0] byt(input logic [P_L*8-1:0] d,
                                     input logic [P_L_LOG2-1:0] i);
    return d[8*i +: 8];
  endfunction

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    held_d  = held_q;
    e_c     = 1'b0;
    s_c     = 1'b0;
    lv_c    = 1'b0;
    chk_c   = 1'b0;
    err_c   = 1'b0;
    eo_c    = '0;
    so_c    = '0;
    len_c   = '0;
    bod_c   = '0;
    r_c     = rem_q[P_L_LOG2-1:0];
    n_c     = '0;
    for (int i = 0; i < P_L; i++) n_c = n_c + ML_W'(keep_i[i]);
    if (valid_i) begin
      unique case (state_q)
        S_LEN: begin
          s_c   = 1'b1;
          lv_c  = 1'b1;
          chk_c = 1'b1;
          len_c = ML_W'({byt(data_i, '0), byt(data_i, P_L_LOG2'(1))});
          bod_c = PL_M2;
        end
        S_SPLIT: begin
          lv_c  = 1'b1;
          chk_c = 1'b1;
          len_c = ML_W'({held_q, byt(data_i, '0)});
          bod_c = PL_M1;
        end
        S_BODY: begin
          if (rem_q > PL_W) begin
            rem_d = rem_q - PL_W;
          end else begin
            e_c  = 1'b1;
            eo_c = P_L_LOG2'(rem_q - ML_W'(1));
            if (rem_q == PL_W) begin
              state_d = S_LEN;
            end else if (rem_q == PL_M1) begin
              s_c     = 1'b1;
              so_c    = P_L_LOG2'(P_L - 1);
              held_d  = byt(data_i, P_L_LOG2'(P_L - 1));
              state_d = S_SPLIT;
            end else begin
              s_c   = 1'b1;
              so_c  = r_c;
              lv_c  = 1'b1;
              chk_c = 1'b1;
              len_c = ML_W'({byt(data_i, r_c), byt(data_i, r_c + 1'b1)});
              bod_c = PL_M2 - rem_q;
            end
          end
        end
        S_DRAIN: ;
      endcase
      // a new message must outlive the beat its length completes in
      if (chk_c) begin
        if (len_c == '0 || len_c <= bod_c) begin
          err_c = 1'b1;
        end else begin
          rem_d   = len_c - bod_c;
          state_d = S_BODY;
        end
      end
      if (last_i && state_q != S_DRAIN) begin
        if (e_c && rem_q == n_c) begin
          s_c   = 1'b0;
          lv_c  = 1'b0;
          err_c = 1'b0;
        end else begin
          err_c = 1'b1;
        end
      end
      if (err_c) begin
        e_c     = 1'b0;
        s_c     = 1'b0;
        lv_c    = 1'b0;
        rem_d   = '0;
        state_d = S_DRAIN;
      end
      if (last_i) begin
        state_d = S_LEN;
        rem_d   = '0;
        held_d  = '0;
      end
    end
    valid_d = valid_i && state_q != S_DRAIN;
    err_d   = err_c;
    end_d   = e_c;
    eoff_d  = e_c ? eo_c : '0;
    start_d = s_c;
    soff_d  = s_c ? so_c : '0;
    ovl_d   = e_c & s_c;
    lv_d    = lv_c;
    len_d   = lv_c ? len_c : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN;
      rem_q   <= '0;
      held_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      eoff_q  <= '0;
      start_q <= 1'b0;
      soff_q  <= '0;
      ovl_q   <= 1'b0;
      lv_q    <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      held_q  <= held_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      eoff_q  <= eoff_d;
      start_q <= start_d;
      soff_q  <= soff_d;
      ovl_q   <= ovl_d;
      lv_q    <= lv_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign valid_o         = valid_q;
  assign msg_end_o       = end_q;
  assign msg_end_off_o   = eoff_q;
  assign msg_start_o     = start_q;
  assign msg_start_off_o = soff_q;
  assign overlap_o       = ovl_q;
  assign len_v_o         = lv_q;
  assign len_o           = len_q;
  assign err_o           = err_q;

`ifdef MOLD_MSG_CNT_EN
  logic [15:0] cnt_q, cnt_d, hdr_q, hdr_d, mcnt_q, mcnt_d;
  logic first_q, first_d, mis_q, mis_d;

  always_comb begin
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    first_d = first_q;
    mcnt_d  = '0;
    mis_d   = 1'b0;
    if (valid_i) begin
      if (first_q) hdr_d = hdr_cnt_i;
      first_d = 1'b0;
      if (end_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      mcnt_d = valid_d ? cnt_d : '0;
      if (last_i) begin
        mis_d   = cnt_d != hdr_d;
        cnt_d   = '0;
        first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      hdr_q   <= '0;
      first_q <= 1'b1;
      mcnt_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      first_q <= first_d;
      mcnt_q  <= mcnt_d;
      mis_q   <= mis_d;
    end
  end

  assign msg_cnt_o      = mcnt_q;
  assign cnt_mismatch_o = mis_q;
`endif

endmodule
